// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for the two-entry skid register.
// The master modport is the environment view and the slave modport is the register view.
interface pipe_skid_reg_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: fully registered valid/ready pipeline stage with one-cycle latency.
// in_ready is a registered output, so there is no combinational path from out_ready to in_ready.
module pipe_skid_reg #(
  parameter int           W        = 32,
  parameter logic [W-1:0] RST_DATA = {W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  pipe_skid_reg_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t       state_r;
  state_t       state_next_s;
  logic [W-1:0] main_r;
  logic [W-1:0] main_next_s;
  logic [W-1:0] skid_r;
  logic [W-1:0] skid_next_s;
  logic         in_ready_r;
  logic         out_valid_r;
  logic [1:0]   occupancy_r;
  logic [1:0]   occupancy_next_s;
  logic         push_s;
  logic         pop_s;

  assign push_s = bus.in_valid & in_ready_r;
  assign pop_s  = out_valid_r & bus.out_ready;

  // Next-state and data-register selection; flush clears only the valid state.
  always_comb begin
    state_next_s = state_r;
    main_next_s  = main_r;
    skid_next_s  = skid_r;
    if (flush) begin
      state_next_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (push_s) begin
            main_next_s  = bus.in_data;
            state_next_s = ONE;
          end else begin
            state_next_s = EMPTY;
          end
        end
        ONE: begin
          if (push_s && pop_s) begin
            main_next_s  = bus.in_data;
            state_next_s = ONE;
          end else if (push_s) begin
            skid_next_s  = bus.in_data;
            state_next_s = TWO;
          end else if (pop_s) begin
            state_next_s = EMPTY;
          end else begin
            state_next_s = ONE;
          end
        end
        TWO: begin
          if (pop_s) begin
            main_next_s  = skid_r;
            state_next_s = ONE;
          end else begin
            state_next_s = TWO;
          end
        end
        default: begin
          state_next_s = EMPTY;
        end
      endcase
    end
  end

  // Occupancy encoding of the upcoming state, so the registered count tracks the state.
  always_comb begin
    occupancy_next_s = 2'd0;
    case (state_next_s)
      EMPTY:   occupancy_next_s = 2'd0;
      ONE:     occupancy_next_s = 2'd1;
      TWO:     occupancy_next_s = 2'd2;
      default: occupancy_next_s = 2'd0;
    endcase
  end

  // State, payload and handshake registers; reset forces in_ready low until the first edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= EMPTY;
      main_r      <= RST_DATA;
      skid_r      <= RST_DATA;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      occupancy_r <= 2'd0;
    end else begin
      state_r     <= state_next_s;
      main_r      <= main_next_s;
      skid_r      <= skid_next_s;
      in_ready_r  <= (state_next_s != TWO);
      out_valid_r <= (state_next_s != EMPTY);
      occupancy_r <= occupancy_next_s;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = main_r;
  assign bus.occupancy = occupancy_r;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations and a long random handshake run.
module tb_pipe_skid_reg;

  localparam int         W     = 8;
  localparam logic [7:0] RST_V = 8'hA5;

  logic clk;
  logic rst;
  logic flush;
  int   errors;
  int   checks;
  bit   started;

  pipe_skid_reg_if #(.W(W)) bus ();

  pipe_skid_reg #(.W(W), .RST_DATA(RST_V)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the held entries as a FIFO queue, plus the last front value.
  logic [7:0] mq[$];
  bit         m_ready;
  logic [7:0] m_last;
  int         pushed;
  int         popped;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge rst) begin
    mq.delete();
    m_ready = 1'b0;
    m_last  = RST_V;
  end

  // Model update on each rising edge, from the inputs and the model's own handshake view.
  always @(posedge clk) begin
    if (rst) begin
      bit do_push;
      bit do_pop;
      do_push = bus.in_valid && m_ready;
      do_pop  = (mq.size() > 0) && bus.out_ready;
      if (flush) begin
        mq.delete();
      end else begin
        if (do_pop) begin
          void'(mq.pop_front());
          popped++;
        end
        if (do_push) begin
          mq.push_back(bus.in_data);
          pushed++;
        end
      end
      if (mq.size() > 0) m_last = mq[0];
      m_ready = (mq.size() < 2);
    end
  end

  // Compare process: every falling edge, all DUT outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready",  {31'd0, bus.in_ready},  {31'd0, m_ready});
      chk("out_valid", {31'd0, bus.out_valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
      chk("occupancy", {30'd0, bus.occupancy}, mq.size());
      chk("out_data",  {24'd0, bus.out_data},  {24'd0, (mq.size() > 0) ? mq[0] : m_last});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit r, input bit f);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    flush         = f;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    pushed  = 0;
    popped  = 0;
    started = 1'b0;
    m_ready = 1'b0;
    m_last  = RST_V;
    rst     = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    started = 1'b1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    chk("rst_occupancy", {30'd0, bus.occupancy}, 32'd0);
    chk("rst_out_data",  {24'd0, bus.out_data},  32'hA5);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("in_ready_after_rst", {31'd0, bus.in_ready}, 32'd1);

    // Streaming with out_ready held high: one-cycle latency, full throughput.
    drive(1'b1, 8'h0A, 1'b1, 1'b0); cyc();
    chk("stream_a", {24'd0, bus.out_data}, 32'h0A);
    chk("stream_a_valid", {31'd0, bus.out_valid}, 32'd1);
    drive(1'b1, 8'h0B, 1'b1, 1'b0); cyc();
    chk("stream_b", {24'd0, bus.out_data}, 32'h0B);
    chk("stream_b_valid", {31'd0, bus.out_valid}, 32'd1);
    drive(1'b1, 8'h0C, 1'b1, 1'b0); cyc();
    chk("stream_c", {24'd0, bus.out_data}, 32'h0C);
    drive(1'b0, 8'h00, 1'b1, 1'b0); cyc();
    chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("drain_hold",  {24'd0, bus.out_data}, 32'h0C);

    // Back-pressure fills both entries, then drains in order.
    drive(1'b1, 8'h11, 1'b0, 1'b0); cyc();
    drive(1'b1, 8'h22, 1'b0, 1'b0); cyc();
    chk("full_occ",   {30'd0, bus.occupancy}, 32'd2);
    chk("full_ready", {31'd0, bus.in_ready},  32'd0);
    chk("full_data",  {24'd0, bus.out_data},  32'h11);
    drive(1'b1, 8'h33, 1'b0, 1'b0); cyc();
    chk("blocked_occ",  {30'd0, bus.occupancy}, 32'd2);
    chk("blocked_data", {24'd0, bus.out_data},  32'h11);
    drive(1'b0, 8'h00, 1'b1, 1'b0); cyc();
    chk("pop1_data",  {24'd0, bus.out_data}, 32'h22);
    chk("pop1_ready", {31'd0, bus.in_ready}, 32'd1);
    cyc();
    chk("pop2_occ", {30'd0, bus.occupancy}, 32'd0);

    // Flush in the full state overrides push and pop; data registers keep their contents.
    drive(1'b1, 8'h44, 1'b0, 1'b0); cyc();
    drive(1'b1, 8'h55, 1'b0, 1'b0); cyc();
    drive(1'b1, 8'h66, 1'b1, 1'b1); cyc();
    chk("flush_occ",   {30'd0, bus.occupancy}, 32'd0);
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_ready", {31'd0, bus.in_ready},  32'd1);
    chk("flush_main",  {24'd0, bus.out_data},  32'h44);
    drive(1'b0, 8'h00, 1'b0, 1'b0); cyc();

    // Asynchronous reset between edges while holding one entry.
    drive(1'b1, 8'h77, 1'b0, 1'b0); cyc();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_data",  {24'd0, bus.out_data},  32'hA5);
    chk("async_occ",   {30'd0, bus.occupancy}, 32'd0);
    cyc();
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("async_ready_back", {31'd0, bus.in_ready}, 32'd1);

    // Random handshaking; the every-cycle compare covers ordering and in_ready in the full state.
    pushed = 0;
    popped = 0;
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(1, 0)), 8'($urandom), 1'($urandom_range(1, 0)), 1'b0);
      cyc();
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    cyc();
    cyc();
    cyc();
    chk("conservation", popped, pushed);
    chk("final_empty", {30'd0, bus.occupancy}, 32'd0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001: Parameter W, default 32, SHALL set the data width in bits, legal range 1..128.
REQ-002: Parameter RST_DATA, default 0 (W bits), SHALL set the value loaded into both data registers on reset.
REQ-003: clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004: rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-005: flush  input  1  SHALL be a synchronous request to discard all held entries.
REQ-006: in_valid  input  1  SHALL indicate that the upstream stage presents data.
REQ-007: in_ready  output  1  SHALL indicate that the block accepts data this cycle.
REQ-008: in_data  input  W  SHALL be the upstream payload.
REQ-009: out_valid  output  1  SHALL indicate that out_data holds a valid entry.
REQ-010: out_ready  input  1  SHALL indicate that the downstream stage consumes data this cycle.
REQ-011: out_data  output  W  SHALL be the payload of the oldest held entry.
REQ-012: occupancy  output  2  SHALL report the number of held entries (0, 1 or 2).

Function
REQ-013: An input transfer SHALL occur when in_valid and in_ready are both 1 at a rising edge; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-014: The block SHALL hold two W-bit registers: main (drives out_data) and skid.
REQ-015: The state machine SHALL have three states: EMPTY (occupancy 0), ONE (main valid), TWO (main and skid valid).
REQ-016: in_ready SHALL be a registered output equal to 1 in states EMPTY and ONE, and 0 in state TWO; it SHALL have no combinational path from out_ready.
REQ-017: out_valid SHALL be 1 exactly in states ONE and TWO, driven from a register.
REQ-018: EMPTY, on an input transfer: main <= in_data, next state ONE.
REQ-019: ONE, on an input transfer with an output transfer: main <= in_data, state stays ONE.
REQ-020: ONE, on an input transfer without an output transfer: skid <= in_data, next state TWO.
REQ-021: ONE, on an output transfer only: next state EMPTY; main retains its value.
REQ-022: TWO, on an output transfer: main <= skid, next state ONE; no input transfer is possible in this state.
REQ-023: With no transfers, the state and both data registers SHALL hold.
REQ-024: Latency SHALL be one cycle: data accepted at edge k appears on out_data after edge k when the block was EMPTY.
REQ-025: Throughput SHALL be one transfer per cycle when out_ready is held at 1.
REQ-026: Ordering SHALL be strictly first-in, first-out; no entry SHALL be duplicated or lost except by flush.
REQ-027: flush=1 SHALL force the next state to EMPTY, overriding every transfer that cycle; in_data presented that cycle SHALL be dropped; in_ready SHALL be 1 in the following cycle.
REQ-028: Flush SHALL NOT alter the main or skid data registers; only the valid state SHALL clear.
REQ-029: occupancy SHALL be consistent with the state in the same cycle (EMPTY=0, ONE=1, TWO=2); the value 3 SHALL never occur.

Reset
REQ-030: While rst=0 the block SHALL immediately, without waiting for a clock edge, enter EMPTY with out_valid=0, in_ready=0, occupancy=0, and main=skid=RST_DATA.
REQ-031: in_ready SHALL become 1 at the first rising edge after rst is deasserted.
REQ-032: Reset asserted mid-operation SHALL discard all held entries, with the same result as REQ-030.

Verification
REQ-033: Reset, then in_valid=1 with in_data 0xA, 0xB, 0xC on consecutive cycles and out_ready=1 -> out_data is 0xA, 0xB, 0xC, one cycle later each, with out_valid continuously 1.
REQ-034: out_ready=0, push 0x11 then 0x22 -> occupancy=2, in_ready=0, out_data=0x11; raise out_ready -> 0x11 then 0x22 emerge and in_ready returns to 1 after the first pop.
REQ-035: State TWO with in_valid=1 and in_data=0x33 while in_ready=0 -> 0x33 is not accepted and occupancy stays 2.
REQ-036: State TWO, assert flush together with out_ready=1 and in_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1, and no output transfer is counted.
REQ-037: Drive rst=0 between clock edges while in state ONE -> out_valid=0 and out_data=RST_DATA before the next edge.
REQ-038: Random in_valid/out_ready at 50% for 10,000 cycles with W=8 -> the output sequence equals the input sequence exactly, and in_ready is never 1 in state TWO.
